// File: rtl/rib_wait_slave_pkg.sv
// Shared constants for the RIB wait-state responder: FSM encodings, counter width, address fields.
// Also holds the address-legality helper used at capture time.
package rib_wait_slave_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned RIB_WAIT_CNT_W = 4;

  localparam int unsigned BASE_MSB = 31;
  localparam int unsigned BASE_LSB = 28;

  // Legal when the slave select matches, the address is word aligned, and nothing is set
  // between the top of the word-index field and the slave select.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [3:0] base,
                                   input int unsigned idx_w);
    return (addr[BASE_MSB:BASE_LSB] == base) &&
           (addr[1:0] == 2'b00) &&
           ((addr[BASE_LSB-1:0] >> (idx_w + 2)) == '0);
  endfunction

endpackage

// File: rtl/rib_sram_array.sv
// Single-port word array with synchronous write and registered read.
// The read register updates on every clock edge, so rdata lags idx by one cycle.
module rib_sram_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/rib_wait_slave.sv
// RIB slave: SRAM behind a wait-state sequencer; ack_o after WAIT_CYCLES+1 cycles.
// hold_o stalls the master from the capture cycle until the response; req_i is sampled only in IDLE.
module rib_wait_slave
  import rib_wait_slave_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [3:0]  BASE_SEL    = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        hold_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [RIB_WAIT_CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? RIB_WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  logic [1:0]                state, nxt;
  logic [RIB_WAIT_CNT_W-1:0] cnt;
  logic [IDX_W-1:0]          cap_idx, sram_idx;
  logic [31:0]               cap_dat, data_q, rdata;
  logic                      cap_we, cap_ok;
  logic                      ack_q, err_q, rd_q;
  logic                      live_ok, src_ok, src_we, mem_we;

  assign live_ok = addr_ok(addr_i, BASE_SEL, IDX_W);
  // With zero wait states the response is decided on the capture edge, from the live inputs.
  assign src_ok  = (state == ST_IDLE) ? live_ok : cap_ok;
  assign src_we  = (state == ST_IDLE) ? we_i : cap_we;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (req_i) nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == '0) nxt = ST_RESP;
      ST_RESP: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cap_idx <= '0;
      cap_dat <= '0;
      cap_we  <= 1'b0;
      cap_ok  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && req_i) begin
        cap_idx <= addr_i[IDX_W+1:2];
        cap_dat <= data_i;
        cap_we  <= we_i;
        cap_ok  <= live_ok;
        cnt     <= CNT_LOAD;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - RIB_WAIT_CNT_W'(1);
      end
      ack_q <= (nxt == ST_RESP);
      if (nxt == ST_RESP) begin
        err_q <= ~src_ok;
        rd_q  <= src_ok & ~src_we;
      end
      if (ack_q) data_q <= data_o;
    end
  end

  // The read register is addressed by the live bus in IDLE so a zero-wait read is ready in RESP.
  assign sram_idx = (state == ST_IDLE) ? addr_i[IDX_W+1:2] : cap_idx;
  assign mem_we   = ack_q & cap_ok & cap_we & ~rst;

  rib_sram_array #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .idx   (sram_idx),
    .wdata (cap_dat),
    .rdata (rdata)
  );

  assign data_o = ack_q ? (rd_q ? rdata : '0) : data_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign hold_o = ~rst & (((state == ST_IDLE) & req_i) | (state == ST_WAIT));

endmodule

// File: tb/tb_rib_wait_slave.sv
// Directed bench for rib_wait_slave: one instance with two wait states, one with none.
module tb_rib_wait_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        req2, we2, ack2, err2, hold2;
  logic [31:0] addr2, wd2, rd2;
  logic        req0, we0, ack0, err0, hold0;
  logic [31:0] addr0, wd0, rd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rib_wait_slave #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_SEL(4'h1)) u_dut2 (
    .clk(clk), .rst(rst), .req_i(req2), .we_i(we2), .addr_i(addr2), .data_i(wd2),
    .data_o(rd2), .ack_o(ack2), .err_o(err2), .hold_o(hold2)
  );

  rib_wait_slave #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_SEL(4'h1)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .data_i(wd0),
    .data_o(rd0), .ack_o(ack0), .err_o(err0), .hold_o(hold0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Two-wait access: hold for three cycles, ack in the fourth.
  task automatic acc2(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e, input string tag);
    @(posedge clk); #1;
    req2 = 1'b1; we2 = wr; addr2 = a; wd2 = wd;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {31'b0, hold2}, 32'd1);
      chk({tag, "_ack_early"}, {31'b0, ack2}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_ack"}, {31'b0, ack2}, 32'd1);
    chk({tag, "_hold_resp"}, {31'b0, hold2}, 32'd0);
    chk({tag, "_data"}, rd2, exp_d);
    chk({tag, "_err"}, {31'b0, err2}, {31'b0, exp_e});
    @(posedge clk); #1;
    req2 = 1'b0;
  endtask

  // Zero-wait access: hold in the capture cycle, ack in the next.
  task automatic acc0(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e, input string tag);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = wr; addr0 = a; wd0 = wd;
    @(negedge clk);
    chk({tag, "_hold"}, {31'b0, hold0}, 32'd1);
    chk({tag, "_ack_early"}, {31'b0, ack0}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_ack"}, {31'b0, ack0}, 32'd1);
    chk({tag, "_hold_resp"}, {31'b0, hold0}, 32'd0);
    chk({tag, "_data"}, rd0, exp_d);
    chk({tag, "_err"}, {31'b0, err0}, {31'b0, exp_e});
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wd2 = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack2", {31'b0, ack2}, 32'd0);
    chk("rst_err2", {31'b0, err2}, 32'd0);
    chk("rst_hold2", {31'b0, hold2}, 32'd0);
    chk("rst_data2", rd2, 32'd0);
    chk("rst_ack0", {31'b0, ack0}, 32'd0);
    chk("rst_data0", rd0, 32'd0);

    // Seed words used as untouched references later.
    acc2(1'b1, 32'h1000_0000, 32'hA5A5_0000, 32'd0, 1'b0, "w_word0");
    acc2(1'b1, 32'h1000_0020, 32'h0BAD_0BAD, 32'd0, 1'b0, "w_word8");

    acc2(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, "w_beef");
    acc2(1'b0, 32'h1000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, "r_beef");
    @(negedge clk);
    chk("r_beef_data_hold", rd2, 32'hDEAD_BEEF);

    acc2(1'b0, 32'h1000_0012, 32'd0, 32'd0, 1'b1, "r_misalign");
    @(negedge clk);
    chk("misalign_err_hold", {31'b0, err2}, 32'd1);
    chk("misalign_data_hold", rd2, 32'd0);
    acc2(1'b0, 32'h1000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, "r_after_mis");

    acc2(1'b1, 32'h2000_0000, 32'h1111_1111, 32'd0, 1'b1, "w_badsel");
    acc2(1'b1, 32'h1000_1000, 32'h2222_2222, 32'd0, 1'b1, "w_badidx");
    acc2(1'b0, 32'h1000_0000, 32'd0, 32'hA5A5_0000, 1'b0, "r_word0");

    // Address change and req drop during WAIT must not disturb the captured read.
    @(posedge clk); #1;
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'h1000_0010;
    @(negedge clk);
    chk("abort_hold_c0", {31'b0, hold2}, 32'd1);
    @(posedge clk); #1;
    addr2 = 32'h1000_0020; req2 = 1'b0;
    @(negedge clk);
    chk("abort_hold_c1", {31'b0, hold2}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_hold_c2", {31'b0, hold2}, 32'd1);
    chk("abort_ack_c2", {31'b0, ack2}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ack_c3", {31'b0, ack2}, 32'd1);
    chk("abort_data", rd2, 32'hDEAD_BEEF);
    chk("abort_err", {31'b0, err2}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_ack_after", {31'b0, ack2}, 32'd0);
      chk("abort_hold_after", {31'b0, hold2}, 32'd0);
    end

    // Reset while a write is waiting: the write must be dropped.
    acc2(1'b1, 32'h1000_0014, 32'h5555_5555, 32'd0, 1'b0, "w_word5");
    @(posedge clk); #1;
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h1000_0014; wd2 = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req2 = 1'b0;
    @(negedge clk);
    chk("rstmid_hold", {31'b0, hold2}, 32'd0);
    chk("rstmid_ack", {31'b0, ack2}, 32'd0);
    chk("rstmid_err", {31'b0, err2}, 32'd0);
    chk("rstmid_data", rd2, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstmid_ack_later", {31'b0, ack2}, 32'd0);
      chk("rstmid_hold_later", {31'b0, hold2}, 32'd0);
    end
    acc2(1'b0, 32'h1000_0014, 32'd0, 32'h5555_5555, 1'b0, "r_word5");

    // Zero-wait instance: preload, then back-to-back reads with req held high.
    for (int i = 0; i < 4; i++)
      acc0(1'b1, 32'h1000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 32'd0, 1'b0, "w0_pre");
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1000_0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("seq_ack_cap", {31'b0, ack0}, 32'd0);
      @(posedge clk); #1;
      addr0 = 32'h1000_0100 + 32'(4 * (i + 1));
      @(negedge clk);
      chk("seq_ack_resp", {31'b0, ack0}, 32'd1);
      chk("seq_data", rd0, 32'hC0DE_0000 + 32'(i));
      @(posedge clk); #1;
    end
    req0 = 1'b0;

    acc0(1'b1, 32'h1000_0FFC, 32'h7FFF_0001, 32'd0, 1'b0, "w0_last");
    acc0(1'b0, 32'h1000_0FFC, 32'd0, 32'h7FFF_0001, 1'b0, "r0_last");
    acc0(1'b0, 32'h1000_0101, 32'd0, 32'd0, 1'b1, "r0_misalign");
    acc0(1'b0, 32'h1000_0104, 32'd0, 32'hC0DE_0001, 1'b0, "r0_after_mis");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
